// File: rtl/rr_sel4_scheduler.sv
// ---------------------------------------------------------------------------
// rr_sel4_scheduler
//   Round-robin scheduler that drives the 2-bit select of a 4:1 mux. It grants
//   one requesting channel at a time and holds s/grant constant for a burst. It
//   rotates the grant after MAX_BURST accepted beats, or earlier when the
//   granted channel drops its request. A single IDLE cycle always separates
//   two consecutive grants.
//
// Parameters
//   BURST_W    width of the beat counter
//   MAX_BURST  beats per grant before forced rotation (0 = unlimited);
//              must be < 2**BURST_W
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req[3:0]   req[k]=1: channel k has a beat on mux input k
//   out_ready  downstream accepts the muxed beat this cycle
//   s[1:0]     registered mux select
//   grant[3:0] registered one-hot grant, 0 while idle
//   out_valid  muxed output holds a valid beat (SERVE & req[s])
//   busy       1 while serving a grant
// ---------------------------------------------------------------------------
module rr_sel4_scheduler #(
  parameter int unsigned BURST_W   = 3,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       out_ready,
  output logic [1:0] s,
  output logic [3:0] grant,
  output logic       out_valid,
  output logic       busy
);

  typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_e;

  // Last beat index of a burst; unused when MAX_BURST == 0.
  localparam int unsigned          LAST_I = (MAX_BURST == 0) ? 0 : MAX_BURST - 1;
  localparam logic [BURST_W-1:0]   LAST   = LAST_I[BURST_W-1:0];

  state_e             state_q;
  logic [1:0]         ptr_q;
  logic [1:0]         s_q;
  logic [3:0]         grant_q;
  logic [BURST_W-1:0] cnt_q;

  logic               pick_vld;
  logic [1:0]         pick_ch;
  logic [1:0]         idx;
  logic               xfer;
  logic               burst_end;
  logic               req_drop;

  // Rotating priority search starting at ptr. The loop runs from the farthest
  // offset down to offset 0, so the requester nearest to ptr wins. The 2-bit
  // index wraps mod 4 on its own.
  always_comb begin
    pick_vld = 1'b0;
    pick_ch  = ptr_q;
    idx      = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i);
      if (req[idx]) begin
        pick_vld = 1'b1;
        pick_ch  = idx;
      end
    end
  end

  assign busy      = (state_q == SERVE);
  assign out_valid = busy & req[s_q];
  assign xfer      = out_valid & out_ready;
  assign burst_end = (MAX_BURST != 0) && xfer && (cnt_q == LAST);
  assign req_drop  = ~req[s_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      s_q     <= 2'd0;
      grant_q <= 4'b0000;
    end else begin
      case (state_q)
        IDLE: begin
          // s keeps its last value while idle; only a new grant moves it.
          if (pick_vld) begin
            state_q <= SERVE;
            s_q     <= pick_ch;
            grant_q <= 4'b0001 << pick_ch;
            cnt_q   <= '0;
          end
        end
        SERVE: begin
          // The end of a burst and a request drop can coincide. That is still
          // one exit, and ptr advances by one.
          if (burst_end || req_drop) begin
            state_q <= IDLE;
            ptr_q   <= s_q + 2'd1;
            grant_q <= 4'b0000;
            cnt_q   <= '0;
          end else if (xfer) begin
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s     = s_q;
  assign grant = grant_q;

endmodule

// File: tb/tb_rr_sel4_scheduler.sv
module tb_rr_sel4_scheduler;
  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       out_ready = 1'b0;
  logic [1:0] s;
  logic [3:0] grant;
  logic       out_valid;
  logic       busy;

  // Harness mux: inputs i0..i3 hold the constants 0..3, and s selects one.
  logic [3:0] mux_in [4];
  logic [3:0] f;
  assign mux_in[0] = 4'd0;
  assign mux_in[1] = 4'd1;
  assign mux_in[2] = 4'd2;
  assign mux_in[3] = 4'd3;
  assign f = mux_in[s];

  rr_sel4_scheduler #(.BURST_W(3), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .s(s), .grant(grant), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: serving flag, owner channel, beats done, rotation pointer.
  bit m_srv = 0;
  int m_ch = 0, m_beats = 0, m_ptr = 0, m_s = 0;
  bit xfer_seen;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // One rising edge of the model. It uses the inputs that were stable before the edge.
  task automatic model_step();
    bit v;
    if (!rst_n) begin
      m_srv = 0; m_ptr = 0; m_beats = 0; m_s = 0;
    end else if (!m_srv) begin
      for (int i = 0; i < 4; i++) begin
        int k;
        k = (m_ptr + i) % 4;
        if (req[k]) begin
          m_srv = 1; m_ch = k; m_s = k; m_beats = 0;
          break;
        end
      end
    end else begin
      v = req[m_ch];
      if (v && out_ready) m_beats++;
      if ((MB != 0 && m_beats == MB) || !v) begin
        m_srv = 0; m_ptr = (m_ch + 1) % 4; m_beats = 0;
      end
    end
  endtask

  task automatic cmp_model();
    chk("model_s", int'(s), m_s);
    chk("model_grant", int'(grant), m_srv ? (1 << m_ch) : 0);
    chk("model_valid", int'(out_valid), (m_srv && req[m_ch]) ? 1 : 0);
    chk("model_busy", int'(busy), int'(m_srv));
    chk("mux_f", int'(f), m_s);
  endtask

  task automatic step();
    @(negedge clk);
    xfer_seen = out_valid & out_ready;
    @(posedge clk);
    model_step();
    #1;
    cmp_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  function automatic int oh2ch(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g == (4'b0001 << i)) return i;
    return -1;
  endfunction

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       rdy;
    logic [1:0] es;
    logic [3:0] eg;
    logic       ev;
    logic       eb;
  } vec_t;

  vec_t vecs [8];

  initial begin
    // Reset for two cycles, then ch2 alone through one burst and its regrant.
    vecs[0] = '{1'b0, 4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 4'b1111, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 4'b0100, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 4'b0100, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 4'b0100, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 4'b0100, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 4'b0100, 1'b1, 2'd2, 4'b0000, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 4'b0100, 1'b1, 2'd2, 4'b0100, 1'b1, 1'b1};

    for (int i = 0; i < 8; i++) begin
      rst_n = vecs[i].rst_n; req = vecs[i].req; out_ready = vecs[i].rdy;
      step();
      chk($sformatf("vec%0d_s", i), int'(s), int'(vecs[i].es));
      chk($sformatf("vec%0d_grant", i), int'(grant), int'(vecs[i].eg));
      chk($sformatf("vec%0d_valid", i), int'(out_valid), int'(vecs[i].ev));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].eb));
    end

    // All four channels request: grants go 0,1,2,3,0 with 4 beats each.
    begin
      int onset[$];
      int nx;
      logic [3:0] prev;
      do_reset();
      req = 4'b1111; out_ready = 1'b1;
      nx = 0; prev = grant;
      for (int c = 0; c < 25; c++) begin
        step();
        if (xfer_seen) nx++;
        if (prev == 4'b0000 && grant != 4'b0000) onset.push_back(oh2ch(grant));
        prev = grant;
      end
      chk("rr_onsets", onset.size(), 5);
      for (int i = 0; i < onset.size() && i < 5; i++)
        chk($sformatf("rr_onset%0d", i), onset[i], i % 4);
      chk("rr_xfers", nx, 20);
    end

    // A stall mid-burst holds the grant, and the burst still totals 4 beats.
    begin
      int n;
      do_reset();
      req = 4'b0010; out_ready = 1'b1;
      step();
      chk("stall_grant", int'(grant), 4'b0010);
      n = 0;
      repeat (2) begin step(); n += int'(xfer_seen); end
      out_ready = 1'b0;
      repeat (3) begin
        step(); n += int'(xfer_seen);
        chk("stall_s", int'(s), 1);
        chk("stall_busy", int'(busy), 1);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
        step(); n += int'(xfer_seen);
        if (!busy) break;
      end
      chk("stall_exit", int'(busy), 0);
      chk("stall_beats", n, 4);
    end

    // Request drop: ch1 leaves after 2 beats, and ptr moves on to ch2.
    do_reset();
    req = 4'b0110; out_ready = 1'b1;
    step();
    chk("drop_grant1", int'(grant), 4'b0010);
    step(); step();
    req = 4'b0100;
    step();
    chk("drop_idle_grant", int'(grant), 0);
    chk("drop_idle_busy", int'(busy), 0);
    step();
    chk("drop_grant2", int'(grant), 4'b0100);
    chk("drop_s2", int'(s), 2);

    // Reset during beat 3 of a ch3 burst. After it, ch3 is regranted from ptr=0.
    do_reset();
    req = 4'b1000; out_ready = 1'b1;
    step();
    chk("rst_mid_grant", int'(grant), 4'b1000);
    step(); step();
    rst_n = 1'b0;
    step();
    chk("rst_mid_g0", int'(grant), 0);
    chk("rst_mid_s0", int'(s), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    step();
    chk("rst_regrant", int'(grant), 4'b1000);
    chk("rst_regrant_s", int'(s), 3);

    // Random traffic against the model. Requests are sticky so that bursts complete.
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
